pbus_tmr: RTL and testbench

//  Timer peripheral on the peripheral bus: the TMR slave fed by the peripheral-bus interconnect's s_tmr_* port group.

---
 rtl/pbus_tmr_pkg.sv | 30 +++
 rtl/pbus_tmr_bus_lane_merge.sv | 23 ++
 rtl/pbus_tmr.sv | 114 +++++++++++
 tb/tb_pbus_tmr.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pbus_tmr_pkg.sv
// pbus_tmr_pkg: bus geometry, access-size codes, timer register offsets and CTRL bit indices
package pbus_tmr_pkg;
    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 3;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);
    localparam int TMR_SIZE    = 16;

    typedef enum logic [ACC_W-1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_e;

    localparam logic [3:0] TMR_CTRL_OFS = 4'h0;
    localparam logic [3:0] TMR_CNT_OFS  = 4'h4;
    localparam logic [3:0] TMR_CMP_OFS  = 4'h8;
    localparam logic [3:0] TMR_STAT_OFS = 4'hC;

    localparam int TMR_CTRL_EN = 0;
    localparam int TMR_CTRL_AR = 1;
    localparam int TMR_CTRL_IE = 2;

    // Byte lanes touched by an access of size acc starting at byte offset ofs
    function automatic logic [3:0] lane_mask(input logic [ACC_W-1:0] acc, input logic [1:0] ofs);
        return (acc == ACC_BYTE) ? 4'b0001 << ofs :
               (acc == ACC_HALF) ? 4'b0011 << ofs :
               (acc == ACC_WORD) ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/pbus_tmr_bus_lane_merge.sv
// bus_lane_merge: merges right-aligned sub-word write data into a register word and flags misaligned accesses
module bus_lane_merge
    import pbus_tmr_pkg::*;
(
    input  logic [BUS_WIDTH-1:0] old_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    input  logic [ACC_W-1:0]     acc_i,
    input  logic [1:0]           ofs_i,
    output logic [BUS_WIDTH-1:0] merged_o,
    output logic                 misal_o
);
    logic [3:0]           mask;
    logic [BUS_WIDTH-1:0] bm;

    // Lane mask expanded to bits; a misaligned or unknown-size access leaves the word untouched
    always_comb begin
        mask     = lane_mask(acc_i, ofs_i);
        bm       = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        misal_o  = (acc_i == ACC_HALF && ofs_i[0]) || (acc_i == ACC_WORD && ofs_i != 2'd0) ||
                   (acc_i != ACC_BYTE && acc_i != ACC_HALF && acc_i != ACC_WORD);
        merged_o = misal_o ? old_i : (old_i & ~bm) | ((wdata_i << {ofs_i, 3'b000}) & bm);
    end
endmodule

// File: rtl/pbus_tmr.sv
// pbus_tmr: TMR peripheral-bus slave, 32-bit up counter with compare match, auto-reload and level irq (prescaler under TMR_PRESC_EN)
module pbus_tmr
    import pbus_tmr_pkg::*;
#(
    parameter int OFS_BITS    = 4,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_req,
    input  logic [XLEN-1:0]      s_addr,
    input  logic                 s_w_rb,
    input  logic [ACC_W-1:0]     s_acc,
    input  logic [BUS_WIDTH-1:0] s_wdata,
    output logic                 s_resp,
    output logic [BUS_WIDTH-1:0] s_rdata,
    output logic                 irq
);
    logic [OFS_BITS-1:0]  ofs;
    logic                 in_map, misal, wr, wr_ctrl, wr_cnt, wr_cmp, wr_stat, tick, hit;
    logic [BUS_WIDTH-1:0] sel, merged, rd_val, smask, ctrl_rd;
    logic [15:0]          presc_ext;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [31:0]          cnt_q, cnt_d, cmp_q, cmp_d, rdata_q;
    logic                 match_q, match_d, irq_q, resp_q;
    logic                 unused_addr;

    assign ofs         = s_addr[OFS_BITS-1:0];
    assign unused_addr = ^s_addr[XLEN-1:OFS_BITS];

`ifdef TMR_PRESC_EN
    logic [PRESC_WIDTH-1:0] presc_q, presc_d, pcnt_q, pcnt_d;

    // Prescaler restarts on every CTRL write and wraps to 0 on each tick; frozen while EN = 0
    always_comb begin
        presc_ext = 16'(presc_q);
        tick      = ctrl_q[TMR_CTRL_EN] && pcnt_q == presc_q;
        presc_d   = wr_ctrl ? merged[16 +: PRESC_WIDTH] : presc_q;
        pcnt_d    = (wr_ctrl || tick) ? '0 : ctrl_q[TMR_CTRL_EN] ? pcnt_q + 1'b1 : pcnt_q;
    end

    // Prescaler state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    logic [PRESC_WIDTH-1:0] unused_presc;

    assign unused_presc = '0;
    assign presc_ext    = '0;
    assign tick         = ctrl_q[TMR_CTRL_EN];
`endif

    bus_lane_merge u_merge (
        .old_i   (sel),
        .wdata_i (s_wdata),
        .acc_i   (s_acc),
        .ofs_i   (ofs[1:0]),
        .merged_o(merged),
        .misal_o (misal)
    );

    // Register select, read extraction and next-state; a CNT write overrides the tick, a new MATCH beats W1C
    always_comb begin
        in_map  = (ofs >> 4) == '0;
        ctrl_rd = {presc_ext, 13'b0, ctrl_q};
        sel     = (ofs[3:2] == TMR_CTRL_OFS[3:2]) ? ctrl_rd :
                  (ofs[3:2] == TMR_CNT_OFS[3:2])  ? cnt_q :
                  (ofs[3:2] == TMR_CMP_OFS[3:2])  ? cmp_q : {31'b0, match_q};
        smask   = (s_acc == ACC_BYTE) ? 32'h0000_00FF : (s_acc == ACC_HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        rd_val  = (in_map && !misal) ? (sel >> {ofs[1:0], 3'b000}) & smask : '0;
        wr      = s_req && s_w_rb && in_map && !misal;
        wr_ctrl = wr && ofs[3:2] == TMR_CTRL_OFS[3:2];
        wr_cnt  = wr && ofs[3:2] == TMR_CNT_OFS[3:2];
        wr_cmp  = wr && ofs[3:2] == TMR_CMP_OFS[3:2];
        wr_stat = wr && ofs[3:2] == TMR_STAT_OFS[3:2];
        hit     = cnt_q == cmp_q;
        ctrl_d  = wr_ctrl ? merged[2:0] : ctrl_q;
        cmp_d   = wr_cmp ? merged : cmp_q;
        cnt_d   = wr_cnt ? merged : !tick ? cnt_q : (hit && ctrl_q[TMR_CTRL_AR]) ? '0 : cnt_q + 1'b1;
        match_d = (tick && !wr_cnt && hit) || (match_q && !(wr_stat && merged[0]));
    end

    // Timer registers, registered irq and single-cycle bus response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            cnt_q   <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_q   <= match_q && ctrl_q[TMR_CTRL_IE];
            resp_q  <= s_req;
            if (s_req && !s_w_rb) rdata_q <= rd_val;
        end
    end

    assign s_resp  = resp_q;
    assign s_rdata = rdata_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_pbus_tmr.sv
// tb_pbus_tmr: directed scoreboard bench for pbus_tmr; define TMR_PRESC_EN to check the prescaled build
module tb_pbus_tmr;
    logic        clk = 1'b0, rst = 1'b1, s_req = 1'b0, s_w_rb = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [1:0]  s_acc = '0;
    logic        s_resp, irq;
    logic [31:0] s_rdata;

    typedef struct {
        int          c;
        logic [31:0] d;
        string       nm;
    } ent_t;

    ent_t        q[$];
    ent_t        me;
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pbus_tmr dut (
        .clk(clk), .rst(rst), .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb),
        .s_acc(s_acc), .s_wdata(s_wdata), .s_resp(s_resp), .s_rdata(s_rdata), .irq(irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Every response must match the oldest request, arrive exactly one cycle later and carry the expected data
    always @(negedge clk) begin
        if (!rst) begin
            if (s_resp) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_resp: got s_resp=1 with no request pending, want 0");
                end else begin
                    me = q.pop_front();
                    chk({me.nm, "_lat"}, cyc, me.c + 1);
                    chk(me.nm, s_rdata, me.d);
                end
            end else if (q.size() != 0 && q[0].c + 1 <= cyc) begin
                me = q.pop_front();
                chk({me.nm, "_resp"}, {31'b0, s_resp}, 32'd1);
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [1:0] acc,
                       input logic [31:0] wd, input logic [31:0] exp, input string nm);
        ent_t e;
        @(negedge clk);
        s_req = 1'b1; s_w_rb = w; s_addr = a; s_acc = acc; s_wdata = wd;
        if (!w) last_rd = exp;
        e.c = cyc; e.d = last_rd; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, 2'd2, d, '0, "wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, a, 2'd2, '0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk) s_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_req = 1'b0; rst = 1'b1; q.delete(); last_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_resp", {31'b0, s_resp}, 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd(32'h0, 32'h0, "rst_ctrl"); rd(32'h4, 32'h0, "rst_cnt");
        rd(32'h8, 32'h0, "rst_cmp");  rd(32'hC, 32'h0, "rst_stat");
        idle(2);
        chk("rst_irq2", {31'b0, irq}, 32'd0);

        // compare match with auto-reload and irq
        wr(32'h8, 32'd5);
        wr(32'h0, 32'h7);
        for (int k = 0; k < 6; k++) rd(32'h4, k, "ar_cnt");
        rd(32'h4, 32'd0, "ar_reload");
        chk("irq_before", {31'b0, irq}, 32'd0);
        rd(32'h4, 32'd1, "ar_after");
        chk("irq_set", {31'b0, irq}, 32'd1);
        rd(32'hC, 32'd1, "match_set");
        wr(32'hC, 32'd1);
        rd(32'hC, 32'd0, "match_clr");
        wr(32'h0, 32'h0);
        chk("irq_clr", {31'b0, irq}, 32'd0);
        rd(32'hC, 32'd1, "match_again");
        wr(32'hC, 32'd1);
        rd(32'hC, 32'd0, "clr_while_off");
        rd(32'h4, 32'd0, "cnt_frozen");
        idle(2);
        chk("irq_ie_off", {31'b0, irq}, 32'd0);

        // wrap without match
        do_reset();
        wr(32'h4, 32'hFFFF_FFFE); wr(32'h8, 32'h10); wr(32'h0, 32'h1);
        rd(32'h4, 32'hFFFF_FFFE, "wrap0"); rd(32'h4, 32'hFFFF_FFFF, "wrap1");
        rd(32'h4, 32'h0, "wrap2");         rd(32'hC, 32'h0, "wrap_nomatch");
        wr(32'h0, 32'h0);
        idle(2);

        // sub-word access
        do_reset();
        wr(32'h8, 32'h1122_3344);
        bus(1'b1, 32'h9, 2'd0, 32'hAB, '0, "wr");
        rd(32'h8, 32'h1122_AB44, "byte_merge");
        bus(1'b1, 32'h9, 2'd1, 32'hFFFF, '0, "wr");
        rd(32'h8, 32'h1122_AB44, "misal_wr_ign");
        bus(1'b0, 32'hA, 2'd1, '0, 32'h1122, "half_rd");
        bus(1'b0, 32'hB, 2'd0, '0, 32'h11, "byte_rd");
        bus(1'b0, 32'hA, 2'd2, '0, 32'h0, "misal_word_rd");
        bus(1'b0, 32'h9, 2'd1, '0, 32'h0, "misal_half_rd");
        bus(1'b1, 32'hA, 2'd1, 32'hBEEF, '0, "wr");
        rd(32'h8, 32'hBEEF_AB44, "half_merge");
        bus(1'b0, 32'h8, 2'd0, '0, 32'h44, "byte_rd0");
        bus(1'b1, 32'h7, 2'd0, 32'h5A, '0, "wr");
        rd(32'h4, 32'h5A00_0000, "cnt_lane3");
        wr(32'h0, 32'hFFFF_0000);
`ifdef TMR_PRESC_EN
        rd(32'h0, 32'hFFFF_0000, "ctrl_presc");
`else
        rd(32'h0, 32'h0, "ctrl_presc");
`endif
        wr(32'hC, 32'hFFFF_FFFE);
        rd(32'hC, 32'h0, "stat_bits");
        idle(2);

        // collisions
        do_reset();
        wr(32'h4, 32'h0); wr(32'h8, 32'h100); wr(32'h0, 32'h1);
        rd(32'h4, 32'h0, "col_cnt0");
        wr(32'h4, 32'h50);
        rd(32'h4, 32'h50, "cnt_wr_wins"); rd(32'h4, 32'h51, "cnt_resume");
        wr(32'h8, 32'h55);
        rd(32'h4, 32'h53, "col_cnt1");    rd(32'h4, 32'h54, "col_cnt2");
        wr(32'hC, 32'h1);
        rd(32'hC, 32'h1, "set_beats_w1c");
        wr(32'h0, 32'h0);
        idle(2);
        chk("col_irq_off", {31'b0, irq}, 32'd0);

        // prescaler and reset mid-transfer
        do_reset();
        wr(32'h0, 32'h0003_0001);
        for (int k = 1; k <= 9; k++) begin
`ifdef TMR_PRESC_EN
            rd(32'h4, (k - 1) >> 2, "presc_cnt");
`else
            rd(32'h4, k - 1, "presc_cnt");
`endif
        end
`ifdef TMR_PRESC_EN
        rd(32'h0, 32'h0003_0001, "presc_ctrl");
`else
        rd(32'h0, 32'h0000_0001, "presc_ctrl");
`endif
        rd(32'h4, 32'h0, "dropped");
        @(posedge clk);
        #1;
        rst = 1'b1; s_req = 1'b0; q.delete(); last_rd = '0;
        @(negedge clk);
        chk("midrst_resp", {31'b0, s_resp}, 32'd0);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("no_resp_after_rst", {31'b0, s_resp}, 32'd0);
        rd(32'h0, 32'h0, "post_ctrl"); rd(32'h4, 32'h0, "post_cnt");
        rd(32'h8, 32'h0, "post_cmp");  rd(32'hC, 32'h0, "post_stat");
        idle(3);
        chk("post_irq", {31'b0, irq}, 32'd0);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending requests, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
